capture_ctrl: RTL and testbench

//  Acquisition sequencer for the scope: decimates ADC samples into the 256-deep sample RAM as a circular

---
 rtl/osc_pkg.sv | 28 ++
 rtl/trigger_detect.sv | 46 ++++
 rtl/capture_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared types and constants for the scope acquisition path.
package osc_pkg;

    // Default geometry of the sample RAM and the decimation counter.
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int DEC_W_DEF  = 16;

    // Trigger slope encodings as carried on cfg_slope.
    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

    // Acquisition sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_READOUT   = 3'd4,
        ST_RELEASE   = 3'd5
    } state_e;

    // States in which ADC samples are accepted and written into the RAM.
    function automatic logic is_capture_state(input state_e s);
        return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// Level/slope edge detector working on the stream of accepted samples.
// Each accepted sample is compared with the previous accepted one; an
// edge is only reported once a previous sample exists since the last clear.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              sample_vld_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              slope_i,
    output logic              trig_o
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_vld_q;
    logic              rise_hit_d;
    logic              fall_hit_d;

    // Remember the last accepted sample; a clear forgets history so no edge spans two records.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clear_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (sample_vld_i) begin
            prev_q     <= sample_i;
            prev_vld_q <= 1'b1;
        end
    end

    // Crossing test; the pulse lasts exactly as long as the accepted-sample strobe.
    always_comb begin
        rise_hit_d = (prev_q < level_i) && (sample_i >= level_i);
        fall_hit_d = (prev_q > level_i) && (sample_i <= level_i);
        trig_o     = sample_vld_i && prev_vld_q &&
                     ((slope_i == SLOPE_FALLING) ? fall_hit_d : rise_hit_d);
    end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: decimates ADC samples into a circular sample RAM,
// waits for a trigger, completes a pre/post-trigger record of exactly DEPTH
// samples and then hands the RAM to readout via rd_activate/rd_done.
//
// Readout handshake: rd_activate is a level raised when the record is complete.
// Readout raises rd_done when finished; rd_activate drops on the next edge and
// the sequencer returns to IDLE only after rd_done has been seen low again.
module capture_ctrl
    import osc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEC_W  = DEC_W_DEF
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic              cfg_slope,
    input  logic [ADDR_W-1:0] cfg_pretrig,
    input  logic [DEC_W-1:0]  cfg_decim,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] start_addr,
    output logic              rd_activate,
    input  logic              rd_done,
    output logic              busy,
    output logic              triggered,
    output state_e            dbg_state
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    // Sequencer state and record bookkeeping.
    state_e              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DEC_W-1:0]    dec_cnt_q;
    logic                force_pend_q;

    // Configuration captured on the accepting arm.
    logic [DATA_W-1:0]   level_q;
    logic                slope_q;
    logic [ADDR_W-1:0]   pretrig_q;
    logic [DEC_W-1:0]    decim_q;

    // Registered outputs.
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_wr_addr_q;
    logic [DATA_W-1:0]   mem_wr_data_q;
    logic [ADDR_W-1:0]   start_addr_q;
    logic                rd_activate_q;
    logic                triggered_q;

    // Decoded next-step conditions.
    logic                capture_d;
    logic                arm_go_d;
    logic                accept_d;
    logic [ADDR_W:0]     cnt_inc_d;
    logic [ADDR_W:0]     post_len_d;
    logic                edge_hit_d;
    logic                trig_hit_d;

    trigger_detect #(
        .DATA_W (DATA_W)
    ) u_trigger_detect (
        .clk_i        (clk_50mhz),
        .rst_i        (reset),
        .clear_i      (arm_go_d),
        .sample_vld_i (accept_d),
        .sample_i     (adc_data),
        .level_i      (level_q),
        .slope_i      (slope_q),
        .trig_o       (edge_hit_d)
    );

    // Sample acceptance, record length and trigger qualification for this cycle.
    always_comb begin
        capture_d  = is_capture_state(state_q);
        arm_go_d   = (state_q == ST_IDLE) && arm;
        accept_d   = capture_d && adc_valid && (dec_cnt_q == '0);
        cnt_inc_d  = cnt_q + ONE_C;
        post_len_d = DEPTH_C - {1'b0, pretrig_q};
        // A pending or concurrent force and a real edge on the same sample merge into one trigger.
        trig_hit_d = (state_q == ST_WAIT_TRIG) && accept_d &&
                     (edge_hit_d || force_trig || force_pend_q);
    end

    // Sequencer: decimation, RAM write port, record counting and readout handoff.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            dec_cnt_q     <= '0;
            force_pend_q  <= 1'b0;
            level_q       <= '0;
            slope_q       <= SLOPE_RISING;
            pretrig_q     <= '0;
            decim_q       <= '0;
            mem_we_q      <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            start_addr_q  <= '0;
            rd_activate_q <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;

            // Decimation runs on valid samples only while capturing.
            if (capture_d && adc_valid) begin
                if (dec_cnt_q == '0) begin
                    dec_cnt_q <= decim_q;
                end else begin
                    dec_cnt_q <= dec_cnt_q - 1'b1;
                end
            end

            // Every accepted sample lands in the RAM one cycle later.
            if (accept_d) begin
                mem_we_q      <= 1'b1;
                mem_wr_addr_q <= wr_ptr_q;
                mem_wr_data_q <= adc_data;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        level_q      <= cfg_level;
                        slope_q      <= cfg_slope;
                        pretrig_q    <= cfg_pretrig;
                        decim_q      <= cfg_decim;
                        wr_ptr_q     <= '0;
                        cnt_q        <= '0;
                        dec_cnt_q    <= '0;
                        force_pend_q <= 1'b0;
                        state_q      <= (cfg_pretrig != '0) ? ST_PRE : ST_WAIT_TRIG;
                    end
                end

                ST_PRE: begin
                    if (accept_d) begin
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == {1'b0, pretrig_q}) begin
                            state_q <= ST_WAIT_TRIG;
                        end
                    end
                end

                ST_WAIT_TRIG: begin
                    if (trig_hit_d) begin
                        start_addr_q <= wr_ptr_q - pretrig_q;
                        cnt_q        <= ONE_C;
                        triggered_q  <= 1'b1;
                        force_pend_q <= 1'b0;
                        if (post_len_d == ONE_C) begin
                            rd_activate_q <= 1'b1;
                            state_q       <= ST_READOUT;
                        end else begin
                            state_q <= ST_POST;
                        end
                    end else if (force_trig) begin
                        // No sample this cycle: hold the force for the next accepted one.
                        force_pend_q <= 1'b1;
                    end
                end

                ST_POST: begin
                    if (accept_d) begin
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == post_len_d) begin
                            rd_activate_q <= 1'b1;
                            state_q       <= ST_READOUT;
                        end
                    end
                end

                ST_READOUT: begin
                    if (rd_done) begin
                        rd_activate_q <= 1'b0;
                        state_q       <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!rd_done) begin
                        triggered_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping; busy is a decode of the registered state.
    always_comb begin
        mem_we      = mem_we_q;
        mem_wr_addr = mem_wr_addr_q;
        mem_wr_data = mem_wr_data_q;
        start_addr  = start_addr_q;
        rd_activate = rd_activate_q;
        triggered   = triggered_q;
        busy        = (state_q != ST_IDLE);
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: ramps, falling edges, forced triggers,
// decimation, async reset mid-record and the readout handshake.
`timescale 1ns/1ps
module tb_capture_ctrl;
    import osc_pkg::*;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int DECW = 16;

    logic            clk_50mhz = 1'b0;
    logic            reset = 1'b1;
    logic            arm = 1'b0;
    logic            force_trig = 1'b0;
    logic [DW-1:0]   cfg_level = '0;
    logic            cfg_slope = 1'b0;
    logic [AW-1:0]   cfg_pretrig = '0;
    logic [DECW-1:0] cfg_decim = '0;
    logic [DW-1:0]   adc_data = '0;
    logic            adc_valid = 1'b0;
    logic            rd_done = 1'b0;
    logic [AW-1:0]   mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            mem_we;
    logic [AW-1:0]   start_addr;
    logic            rd_activate;
    logic            busy;
    logic            triggered;
    state_e          dbg_state;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr = '0;
    logic [DW-1:0]    ram_m [0:255];

    capture_ctrl dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .arm         (arm),
        .force_trig  (force_trig),
        .cfg_level   (cfg_level),
        .cfg_slope   (cfg_slope),
        .cfg_pretrig (cfg_pretrig),
        .cfg_decim   (cfg_decim),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_we      (mem_we),
        .start_addr  (start_addr),
        .rd_activate (rd_activate),
        .rd_done     (rd_done),
        .busy        (busy),
        .triggered   (triggered),
        .dbg_state   (dbg_state)
    );

    // Clock: 50 MHz.
    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the next expected {addr,data}.
    always @(negedge clk_50mhz) begin
        if (mem_we === 1'b1) begin
            wr_seen++;
            ram_m[mem_wr_addr] = mem_wr_data;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("wr_addr_data", 32'({mem_wr_addr, mem_wr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic do_arm(input logic [DW-1:0] lvl, input logic slp,
                          input logic [AW-1:0] pre, input logic [DECW-1:0] dec);
        cfg_level   = lvl;
        cfg_slope   = slp;
        cfg_pretrig = pre;
        cfg_decim   = dec;
        arm         = 1'b1;
        exp_addr    = '0;
        step();
        arm = 1'b0;
        // Scramble configuration: the DUT must keep what it latched.
        cfg_level   = DW'($urandom_range(0, 255));
        cfg_slope   = 1'($urandom_range(0, 1));
        cfg_pretrig = AW'($urandom_range(0, 255));
        cfg_decim   = DECW'($urandom_range(0, 65535));
    endtask

    // Drive one valid sample that the bench expects to be written.
    task automatic feed(input logic [DW-1:0] d, input logic ft, input logic ar);
        adc_data   = d;
        adc_valid  = 1'b1;
        force_trig = ft;
        arm        = ar;
        exp_q.push_back({exp_addr, d});
        exp_addr++;
        step();
        adc_valid  = 1'b0;
        force_trig = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    32'(mem_we), 32'd0);
        check({tag, "_addr"},  32'(mem_wr_addr), 32'd0);
        check({tag, "_data"},  32'(mem_wr_data), 32'd0);
        check({tag, "_start"}, 32'(start_addr), 32'd0);
        check({tag, "_rdact"}, 32'(rd_activate), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_trig"},  32'(triggered), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Hold readout busy for a while, then complete the handshake.
    task automatic readout(input string tag, input int hold);
        for (int k = 0; k < hold; k++) begin
            adc_data  = DW'($urandom_range(0, 255));
            adc_valid = 1'b1;
            step();
            check({tag, "_rdact_hold"}, 32'(rd_activate), 32'd1);
        end
        adc_valid = 1'b0;
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        check({tag, "_rdact_drop"}, 32'(rd_activate), 32'd0);
        check({tag, "_release"}, 32'(dbg_state), 32'(ST_RELEASE));
        check({tag, "_busy_rel"}, 32'(busy), 32'd1);
        step();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_trig"}, 32'(triggered), 32'd0);
    endtask

    int trig_i;
    int last_i;

    initial begin
        // Reset state.
        repeat (2) @(posedge clk_50mhz);
        #1;
        check_outputs_zero("rst");
        reset = 1'b0;
        step();
        check_outputs_zero("post_rst");

        // Test 1: rising ramp, level 128, pretrig 4.
        do_arm(8'd128, SLOPE_RISING, 8'd4, 16'd0);
        check("t1_state_pre", 32'(dbg_state), 32'(ST_PRE));
        check("t1_busy", 32'(busy), 32'd1);
        wr_seen = 0;
        trig_i = -1;
        last_i = -1;
        for (int i = 0; i < 600; i++) begin
            feed(DW'(i), 1'b0, 1'b0);
            if (triggered && trig_i < 0) trig_i = i;
            if (rd_activate) begin
                last_i = i;
                break;
            end
        end
        step();
        check("t1_trig_index", 32'(trig_i), 32'd128);
        check("t1_last_index", 32'(last_i), 32'd379);
        check("t1_writes", 32'(wr_seen), 32'd380);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_start_addr", 32'(start_addr), 32'd124);
        check("t1_state_readout", 32'(dbg_state), 32'(ST_READOUT));
        for (int j = 0; j < 256; j++) begin
            logic [7:0] a;
            a = 8'(124 + j);
            check("t1_ram", 32'(ram_m[a]), 32'(a));
        end
        readout("t1", 10);

        // Test 2: falling edge at 100; equal neighbours never trigger.
        do_arm(8'd100, SLOPE_FALLING, 8'd2, 16'd0);
        check("t2_state_pre", 32'(dbg_state), 32'(ST_PRE));
        for (int i = 0; i < 5; i++) feed(8'd100, 1'b0, 1'b0);
        check("t2_flat_no_trig", 32'(triggered), 32'd0);
        check("t2_state_wait", 32'(dbg_state), 32'(ST_WAIT_TRIG));
        for (int v = 200; v >= 101; v--) feed(DW'(v), 1'b0, 1'b0);
        check("t2_no_trig_101", 32'(triggered), 32'd0);
        feed(8'd100, 1'b0, 1'b0);
        check("t2_trig_100", 32'(triggered), 32'd1);
        check("t2_start_addr", 32'(start_addr), 32'd103);
        check("t2_state_post", 32'(dbg_state), 32'(ST_POST));
        for (int v = 99; v >= 80; v--) feed(DW'(v), 1'b0, 1'b0);
        step();
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: asynchronous reset in the middle of POST.
        #4 reset = 1'b1;
        #1;
        check_outputs_zero("t5_async");
        step();
        reset = 1'b0;
        step();

        // Test 3: constant input, force ignored in PRE, forced trigger in WAIT_TRIG.
        // Test 6: arm during POST is ignored.
        do_arm(8'd128, SLOPE_RISING, 8'd3, 16'd0);
        feed(8'd50, 1'b1, 1'b0);
        feed(8'd50, 1'b0, 1'b0);
        feed(8'd50, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) feed(8'd50, 1'b0, 1'b0);
        check("t3_pre_force_ignored", 32'(triggered), 32'd0);
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        check("t3_force_waits_sample", 32'(triggered), 32'd0);
        feed(8'd50, 1'b0, 1'b0);
        check("t3_forced_trig", 32'(triggered), 32'd1);
        check("t3_start_addr", 32'(start_addr), 32'd5);
        for (int idx = 9; idx <= 260; idx++) begin
            feed(DW'(idx), 1'b0, (idx == 100));
            if (idx == 100) check("t6_arm_ignored", 32'(dbg_state), 32'(ST_POST));
            if (idx == 259) check("t3_rdact_before_end", 32'(rd_activate), 32'd0);
        end
        check("t3_rdact_end", 32'(rd_activate), 32'd1);
        step();
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_start_hold", 32'(start_addr), 32'd5);
        readout("t6", 10);

        // Pretrig 255: trigger sample completes the record immediately.
        do_arm(8'd0, SLOPE_RISING, 8'd255, 16'd0);
        for (int i = 0; i < 255; i++) feed(DW'(i), 1'b0, 1'b0);
        check("t7_state_wait", 32'(dbg_state), 32'(ST_WAIT_TRIG));
        feed(8'hAA, 1'b1, 1'b0);
        check("t7_state_readout", 32'(dbg_state), 32'(ST_READOUT));
        check("t7_rdact", 32'(rd_activate), 32'd1);
        check("t7_start_addr", 32'(start_addr), 32'd0);
        step();
        check("t7_queue_empty", 32'(exp_q.size()), 32'd0);
        readout("t7", 2);

        // Test 4: decimation by 3, valid every cycle.
        do_arm(8'd255, SLOPE_RISING, 8'd0, 16'd2);
        check("t4_state_wait", 32'(dbg_state), 32'(ST_WAIT_TRIG));
        for (int i = 0; i < 9; i++) begin
            adc_data  = DW'(10 + i);
            adc_valid = 1'b1;
            if (i % 3 == 0) begin
                exp_q.push_back({exp_addr, DW'(10 + i)});
                exp_addr++;
            end
            step();
            check("t4_we_pattern", 32'(mem_we), (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        adc_valid = 1'b0;
        step();
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t4_no_trig", 32'(triggered), 32'd0);
        #4 reset = 1'b1;
        #1;
        check_outputs_zero("t4_reset");
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
